// File: rtl/mnist_job_arbiter.sv
// mnist_job_arbiter: round-robin job arbiter in front of one MNIST core.
// Ports: req/req_img_sel/grant (job intake), net_* (core side),
//   resp_* (per-requester valid/ready result), busy, clk, rst (async high).
module mnist_job_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int IMG_SEL_W      = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int NUM_CLASSES    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*IMG_SEL_W-1:0] req_img_sel,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       net_start,
    output logic [IMG_SEL_W-1:0]       net_img_sel,
    input  logic                       net_done,
    input  logic [16*NUM_CLASSES-1:0]  net_scores,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [3:0]                 resp_class,
    output logic [15:0]                resp_score,
    output logic                       resp_err,
    output logic                       busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ARGMAX,
        RESP
    } state_t;

    state_t state, state_n;

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       win;
    logic [IDX_W-1:0]       cand;
    logic                   found;
    logic [TMR_W-1:0]       timer;
    logic [3:0]             idx;
    logic [3:0]             best_idx;
    logic signed [15:0]     best;
    logic signed [15:0]     cur;
    logic [16*NUM_CLASSES-1:0] scores;
    logic signed [15:0]     sc [NUM_CLASSES];
    logic [IMG_SEL_W-1:0]   sel [NUM_REQ];
    logic                   done_ok;
    logic                   timeout;
    logic                   last;
    logic                   better;
    logic                   hs;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            sel[k] = req_img_sel[k*IMG_SEL_W +: IMG_SEL_W];
        end
        for (int k = 0; k < NUM_CLASSES; k++) begin
            sc[k] = scores[16*k +: 16];
        end
    end

    // Round-robin search starting just above the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == IDX_W'(NUM_REQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + IDX_W'(1);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // timer is still 0 in the net_start cycle, so a done there is ignored.
    assign done_ok = net_done && (timer != '0);
    assign timeout = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign last    = (idx == 4'(NUM_CLASSES - 1));
    assign cur     = sc[idx];
    assign better  = (idx == 4'd0) || (cur > best);
    assign hs      = resp_ready[owner];

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (found) state_n = WAIT;
            WAIT: begin
                if (done_ok) begin
                    state_n = ARGMAX;
                end else if (timeout) begin
                    state_n = RESP;
                end
            end
            ARGMAX:  if (last) state_n = RESP;
            RESP:    if (hs) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= IDX_W'(NUM_REQ - 1);
            owner       <= '0;
            grant       <= '0;
            net_start   <= 1'b0;
            net_img_sel <= '0;
            timer       <= '0;
            idx         <= '0;
            scores      <= '0;
            best        <= '0;
            best_idx    <= '0;
            resp_class  <= '0;
            resp_score  <= '0;
            resp_err    <= 1'b0;
        end else begin
            grant     <= '0;
            net_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner       <= win;
                        ptr         <= win;
                        net_img_sel <= sel[win];
                        grant       <= NUM_REQ'(1) << win;
                        net_start   <= 1'b1;
                        timer       <= '0;
                    end
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (done_ok) begin
                        scores <= net_scores;
                        idx    <= '0;
                    end else if (timeout) begin
                        resp_err   <= 1'b1;
                        resp_class <= 4'hF;
                        resp_score <= '0;
                    end
                end
                ARGMAX: begin
                    idx <= idx + 4'd1;
                    if (better) begin
                        best     <= cur;
                        best_idx <= idx;
                    end
                    // Final element folds in directly so the result is
                    // registered in the same cycle.
                    if (last) begin
                        resp_err   <= 1'b0;
                        resp_class <= better ? idx : best_idx;
                        resp_score <= better ? cur : best;
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mnist_job_arbiter.sv
// tb_mnist_job_arbiter: randomized self-checking bench for the arbiter.
// Reference model: RR pick over req bits, argmax over a score array.
module tb_mnist_job_arbiter;
    localparam int N  = 2;
    localparam int SW = 4;
    localparam int TO = 100;
    localparam int NC = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*SW-1:0]   req_img_sel;
    logic [N-1:0]      grant;
    logic              net_start;
    logic [SW-1:0]     net_img_sel;
    logic              net_done;
    logic [16*NC-1:0]  net_scores;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [3:0]        resp_class;
    logic [15:0]       resp_score;
    logic              resp_err;
    logic              busy;

    int passed = 0;
    int total  = 0;
    int mptr;
    logic signed [15:0] sv [NC];

    mnist_job_arbiter #(
        .NUM_REQ(N),
        .IMG_SEL_W(SW),
        .TIMEOUT_CYCLES(TO),
        .NUM_CLASSES(NC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_img_sel(req_img_sel),
        .grant(grant),
        .net_start(net_start),
        .net_img_sel(net_img_sel),
        .net_done(net_done),
        .net_scores(net_scores),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_class(resp_class),
        .resp_score(resp_score),
        .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic int ref_class();
        int b = 0;
        for (int i = 1; i < NC; i++) begin
            if (sv[i] > sv[b]) b = i;
        end
        return b;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_scores();
        for (int i = 0; i < NC; i++) net_scores[16*i +: 16] = sv[i];
    endtask

    task automatic rand_scores();
        for (int i = 0; i < NC; i++) sv[i] = 16'($urandom);
        if ($urandom_range(0, 1) == 1)
            sv[$urandom_range(0, NC-1)] = sv[$urandom_range(0, NC-1)];
        set_scores();
    endtask

    task automatic wait_grant(output int c);
        c = 0;
        while (grant == '0 && c < 50) begin
            tick();
            c++;
        end
        if (grant == '0) c = -1;
    endtask

    task automatic wait_resp(output int c);
        c = 0;
        while (resp_valid == '0 && c < 400) begin
            tick();
            c++;
        end
        if (resp_valid == '0) c = -1;
    endtask

    task automatic pulse_done();
        net_done = 1'b1;
        tick();
        net_done = 1'b0;
    endtask

    task automatic ack(input int r);
        resp_ready = '0;
        resp_ready[r] = 1'b1;
        tick();
        resp_ready = '0;
    endtask

    task automatic run_job(input int r, input int dly,
                           output int gw, output int rw);
        req[r] = 1'b1;
        wait_grant(gw);
        req[r] = 1'b0;
        repeat (dly) tick();
        pulse_done();
        wait_resp(rw);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        total++;
        if ({grant, net_start, resp_valid, busy, resp_err} !== '0)
            $display("FAIL reset_ctrl: got %b expected 0",
                     {grant, net_start, resp_valid, busy, resp_err});
        else passed++;
        total++;
        if ({resp_class, resp_score, net_img_sel} !== '0)
            $display("FAIL reset_data: got %h expected 0",
                     {resp_class, resp_score, net_img_sel});
        else passed++;
        rst = 1'b0;
        mptr = N - 1;
        tick();
    endtask

    task automatic test_single();
        int bad = 0;
        for (int i = 0; i < NC; i++)
            sv[i] = 16'(int'($urandom_range(0, 1791)) - 1024);
        sv[7] = 16'h0300;
        set_scores();
        req_img_sel = 8'($urandom);
        req_img_sel[3:0] = 4'd3;
        req = 2'b01;
        tick();
        total++;
        if (grant !== 2'b01 || net_start !== 1'b1)
            $display("FAIL single_grant: got %b/%b expected 01/1",
                     grant, net_start);
        else passed++;
        total++;
        if (net_img_sel !== 4'd3)
            $display("FAIL single_sel: got %0d expected 3", net_img_sel);
        else passed++;
        mptr = 0;
        req = '0;
        pulse_done();
        repeat (48) begin
            tick();
            if (resp_valid !== '0 || busy !== 1'b1) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL single_early_done: got %0d bad cycles expected 0",
                     bad);
        else passed++;
        pulse_done();
        repeat (9) tick();
        total++;
        if (resp_valid !== 2'b00)
            $display("FAIL single_d10: got %b expected 00", resp_valid);
        else passed++;
        tick();
        total++;
        if (resp_valid !== 2'b01)
            $display("FAIL single_d11: got %b expected 01", resp_valid);
        else passed++;
        total++;
        if (resp_class !== 4'(ref_class()) || resp_score !== 16'h0300
            || resp_err !== 1'b0)
            $display("FAIL single_result: got %0d/%h/%b expected %0d/0300/0",
                     resp_class, resp_score, resp_err, ref_class());
        else passed++;
        ack(0);
        total++;
        if (resp_valid !== '0 || busy !== 1'b0)
            $display("FAIL single_release: got %b/%b expected 00/0",
                     resp_valid, busy);
        else passed++;
    endtask

    task automatic test_round_robin();
        int exp, gw, rw;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = N - 1;
        req = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp = rr_pick(req, mptr);
            wait_grant(gw);
            total++;
            if (gw < 0 || grant !== onehot(exp))
                $display("FAIL rr_grant%0d: got %b expected %b",
                         j, grant, onehot(exp));
            else passed++;
            mptr = exp;
            req[exp] = 1'b0;
            rand_scores();
            repeat ($urandom_range(1, 20)) tick();
            pulse_done();
            wait_resp(rw);
            total++;
            if (rw != 10 || resp_valid !== onehot(exp)
                || resp_class !== 4'(ref_class())
                || resp_score !== sv[ref_class()])
                $display("FAIL rr_resp%0d: got %0d/%b/%0d/%h expected 10/%b/%0d/%h",
                         j, rw, resp_valid, resp_class, resp_score,
                         onehot(exp), ref_class(), sv[ref_class()]);
            else passed++;
            ack(exp);
            if (j < 3) req[exp] = 1'b1;
            else req = '0;
        end
        tick();
    endtask

    task automatic test_tie_sign();
        int r, gw, rw;
        for (int i = 0; i < NC; i++) sv[i] = 16'shFF00;
        sv[2] = 16'sh0180;
        sv[5] = 16'sh0180;
        set_scores();
        r = $urandom_range(0, N-1);
        run_job(r, $urandom_range(1, 30), gw, rw);
        mptr = r;
        total++;
        if (gw != 1 || rw != 10)
            $display("FAIL tie_timing: got %0d/%0d expected 1/10", gw, rw);
        else passed++;
        total++;
        if (resp_class !== 4'd2 || resp_score !== 16'h0180)
            $display("FAIL tie_result: got %0d/%h expected 2/0180",
                     resp_class, resp_score);
        else passed++;
        ack(r);
        for (int i = 0; i < NC; i++) sv[i] = 16'sh8000;
        set_scores();
        r = $urandom_range(0, N-1);
        run_job(r, $urandom_range(1, 30), gw, rw);
        mptr = r;
        total++;
        if (rw != 10 || resp_class !== 4'd0 || resp_score !== 16'h8000)
            $display("FAIL min_result: got %0d/%0d/%h expected 10/0/8000",
                     rw, resp_class, resp_score);
        else passed++;
        ack(r);
    endtask

    task automatic test_timeout();
        int r, gw, rw;
        r = $urandom_range(0, N-1);
        req[r] = 1'b1;
        wait_grant(gw);
        req[r] = 1'b0;
        mptr = r;
        wait_resp(rw);
        total++;
        if (rw != TO || resp_valid !== onehot(r))
            $display("FAIL to_latency: got %0d/%b expected %0d/%b",
                     rw, resp_valid, TO, onehot(r));
        else passed++;
        total++;
        if (resp_err !== 1'b1 || resp_class !== 4'hF || resp_score !== 16'h0)
            $display("FAIL to_result: got %b/%h/%h expected 1/f/0000",
                     resp_err, resp_class, resp_score);
        else passed++;
        ack(r);
        pulse_done();
        repeat (5) tick();
        total++;
        if ({busy, resp_valid, grant, net_start} !== '0)
            $display("FAIL to_late_done: got %b expected 0",
                     {busy, resp_valid, grant, net_start});
        else passed++;
        r = $urandom_range(0, N-1);
        req[r] = 1'b1;
        wait_grant(gw);
        req[r] = 1'b0;
        mptr = r;
        rand_scores();
        repeat (TO - 1) tick();
        pulse_done();
        wait_resp(rw);
        total++;
        if (rw != 10 || resp_err !== 1'b0
            || resp_class !== 4'(ref_class()))
            $display("FAIL to_done_wins: got %0d/%b/%0d expected 10/0/%0d",
                     rw, resp_err, resp_class, ref_class());
        else passed++;
        ack(r);
    endtask

    task automatic test_backpressure();
        int r, o, gw, rw, bad;
        logic [3:0]  c0;
        logic [15:0] s0;
        logic        e0;
        r = $urandom_range(0, N-1);
        o = 1 - r;
        rand_scores();
        run_job(r, $urandom_range(1, 40), gw, rw);
        mptr = r;
        req[o] = 1'b1;
        req_img_sel = 8'($urandom);
        c0 = resp_class;
        s0 = resp_score;
        e0 = resp_err;
        bad = 0;
        repeat (20) begin
            resp_ready = '0;
            resp_ready[o] = 1'($urandom);
            tick();
            if (resp_valid !== onehot(r) || resp_class !== c0
                || resp_score !== s0 || resp_err !== e0 || grant !== '0)
                bad++;
        end
        resp_ready = '0;
        total++;
        if (bad != 0)
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        else passed++;
        total++;
        if (resp_class !== 4'(ref_class()) || resp_score !== sv[ref_class()])
            $display("FAIL bp_result: got %0d/%h expected %0d/%h",
                     resp_class, resp_score, ref_class(), sv[ref_class()]);
        else passed++;
        ack(r);
        total++;
        if (resp_valid !== '0)
            $display("FAIL bp_release: got %b expected 00", resp_valid);
        else passed++;
        wait_grant(gw);
        total++;
        if (gw != 1 || grant !== onehot(rr_pick(req, mptr)))
            $display("FAIL bp_next_grant: got %0d/%b expected 1/%b",
                     gw, grant, onehot(rr_pick(req, mptr)));
        else passed++;
        total++;
        if (net_img_sel !== req_img_sel[o*SW +: SW])
            $display("FAIL bp_sel: got %h expected %h",
                     net_img_sel, req_img_sel[o*SW +: SW]);
        else passed++;
        mptr = o;
        req[o] = 1'b0;
        repeat (5) tick();
        pulse_done();
        wait_resp(rw);
        ack(o);
    endtask

    task automatic test_reset_midjob();
        int r, gw, rw, bad;
        r = $urandom_range(0, N-1);
        rand_scores();
        req[r] = 1'b1;
        wait_grant(gw);
        req[r] = 1'b0;
        repeat (5) tick();
        pulse_done();
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if ({grant, net_start, resp_valid, busy, resp_err} !== '0
            || {resp_class, resp_score, net_img_sel} !== '0)
            $display("FAIL rst_async: got %b/%h expected 0/0",
                     {grant, net_start, resp_valid, busy, resp_err},
                     {resp_class, resp_score, net_img_sel});
        else passed++;
        tick();
        rst = 1'b0;
        mptr = N - 1;
        bad = 0;
        repeat (15) begin
            tick();
            if ({resp_valid, busy, grant} !== '0) bad++;
        end
        total++;
        if (bad != 0)
            $display("FAIL rst_stale: got %0d bad cycles expected 0", bad);
        else passed++;
        req = 2'b10;
        wait_grant(gw);
        total++;
        if (grant !== onehot(rr_pick(2'b10, mptr)))
            $display("FAIL rst_grant10: got %b expected %b",
                     grant, onehot(rr_pick(2'b10, mptr)));
        else passed++;
        mptr = 1;
        req = '0;
        repeat (4) tick();
        pulse_done();
        wait_resp(rw);
        total++;
        if (rw != 10 || resp_valid !== 2'b10)
            $display("FAIL rst_job_resp: got %0d/%b expected 10/10",
                     rw, resp_valid);
        else passed++;
        ack(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = N - 1;
        req = 2'b11;
        wait_grant(gw);
        total++;
        if (grant !== onehot(rr_pick(2'b11, mptr)))
            $display("FAIL rst_grant11: got %b expected %b",
                     grant, onehot(rr_pick(2'b11, mptr)));
        else passed++;
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = N - 1;
        tick();
    endtask

    task automatic test_random();
        int exp, gw, rw;
        for (int j = 0; j < 8; j++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            req_img_sel = (N*SW)'($urandom);
            rand_scores();
            exp = rr_pick(req, mptr);
            wait_grant(gw);
            total++;
            if (gw != 1 || grant !== onehot(exp)
                || net_img_sel !== req_img_sel[exp*SW +: SW])
                $display("FAIL rnd_grant%0d: got %0d/%b/%h expected 1/%b/%h",
                         j, gw, grant, net_img_sel, onehot(exp),
                         req_img_sel[exp*SW +: SW]);
            else passed++;
            mptr = exp;
            req[exp] = 1'b0;
            repeat ($urandom_range(1, 80)) tick();
            pulse_done();
            wait_resp(rw);
            total++;
            if (rw != 10 || resp_valid !== onehot(exp) || resp_err !== 1'b0)
                $display("FAIL rnd_valid%0d: got %0d/%b/%b expected 10/%b/0",
                         j, rw, resp_valid, resp_err, onehot(exp));
            else passed++;
            total++;
            if (resp_class !== 4'(ref_class())
                || resp_score !== sv[ref_class()])
                $display("FAIL rnd_result%0d: got %0d/%h expected %0d/%h",
                         j, resp_class, resp_score, ref_class(),
                         sv[ref_class()]);
            else passed++;
            repeat ($urandom_range(0, 5)) begin
                resp_ready = '0;
                resp_ready[1 - exp] = 1'($urandom);
                tick();
            end
            ack(exp);
        end
        req = '0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req = '0;
        req_img_sel = '0;
        net_done = 1'b0;
        net_scores = '0;
        resp_ready = '0;
        mptr = N - 1;
        test_reset();
        test_single();
        test_round_robin();
        test_tie_sign();
        test_timeout();
        test_backpressure();
        test_reset_midjob();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mnist_job_arbiter.md
Name: mnist_job_arbiter

Overview:
Shares the single MNIST inference core (controller, image ROM, three nn_layer stages, softmax) between NUM_REQ requesters.
- Round-robin arbitration selects one job at a time.
- For the granted job the block pulses the core start, passes the image select, and waits for the core done (watchdog-protected).
- It reduces the ten Q8.8 scores to a class with a sequential argmax and returns class and score to the owning requester over a valid/ready handshake.
- It sits directly above mnist_top, replacing the testbench-side argmax.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IMG_SEL_W, 4, width of per-requester image select
TIMEOUT_CYCLES, 200000, max cycles from net_start to net_done before error response
NUM_CLASSES, 10, scores on net_scores (fixed 10 for mnist_top)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester job request, level
req_img_sel  in  NUM_REQ*IMG_SEL_W  image select, slice k for requester k
grant  out  NUM_REQ  one-hot, one-cycle job-accept pulse
net_start  out  1  one-cycle start pulse to mnist_top
net_img_sel  out  IMG_SEL_W  latched image select for core
net_done  in  1  core done (softmax out_valid)
net_scores  in  16*NUM_CLASSES  Q8.8 signed scores, score i at bits [16i+15:16i]
resp_valid  out  NUM_REQ  one-hot response valid
resp_ready  in  NUM_REQ  per-requester response ready
resp_class  out  4  winning class index, 4'hF on error
resp_score  out  16  winning Q8.8 score, 0 on error
resp_err  out  1  1 = watchdog timeout
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE.
  - grant, net_start, resp_valid, resp_class, resp_score, resp_err, busy, net_img_sel all 0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-job abandons the job; no response is issued.
- States: IDLE, WAIT, ARGMAX, RESP.
- IDLE, any req bit set in cycle T:
  - Winner = first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Latch winner index, winner's req_img_sel slice (onto net_img_sel) and pointer=winner.
  - In T+1: grant[winner]=1 and net_start=1 (both single-cycle), state=WAIT, timer=0.
- Requester contract: drop req after seeing grant. A req still high when the block returns to IDLE is a new job. Requests arriving while busy wait; they are never lost while held.
- WAIT:
  - Timer increments every cycle.
  - net_done is ignored in the net_start cycle itself.
  - net_done=1 (after that cycle): register net_scores, state=ARGMAX, i=0.
  - Timer reaching TIMEOUT_CYCLES-1 without net_done: resp_err=1, resp_class=4'hF, resp_score=0, state=RESP.
  - If net_done and timeout occur in the same cycle, net_done wins.
- ARGMAX, one score per cycle, i=0..NUM_CLASSES-1:
  - i=0 loads best.
  - i>0 replaces best only if score[i] > best (signed 16-bit compare, strict). Ties therefore keep the lowest index.
  - After i=NUM_CLASSES-1: resp_class, resp_score, resp_err=0 registered; state=RESP.
  - With net_done sampled in cycle D, resp_valid rises in cycle D+NUM_CLASSES+1 (D+11).
- RESP:
  - resp_valid[winner]=1 and the resp_class/resp_score/resp_err buses are held stable until resp_ready[winner]=1.
  - resp_ready of other requesters is ignored.
  - On handshake cycle: resp_valid deasserts next cycle, state=IDLE. A new grant can issue at the earliest 2 cycles after the handshake.
- net_done outside WAIT is ignored; no state change.
- busy=1 from the grant cycle through the handshake cycle.
- Output data buses are don't-care-free: they hold their last value outside RESP.

Test Plan:
1. Single job, req=2'b01, sel0=3; core returns net_done 50 cycles later with scores[7]=0x0300, others below it → grant=01 and net_start one cycle after req; net_img_sel=3; resp_valid=01 at done+11; resp_class=7, resp_score=0x0300, resp_err=0.
2. Round robin: req=2'b11 held, each requester re-raising after its response → grant order 0,1,0,1 over four jobs.
3. Tie and sign: scores[2]=scores[5]=0x0180, all others negative (0xFF00) → class=2. All scores 0x8000 → class=0, score=0x8000.
4. Timeout with TIMEOUT_CYCLES=100 and no net_done → resp_err=1, class=4'hF, score=0, resp_valid exactly 100 cycles after net_start. A late net_done afterwards is ignored.
5. Backpressure: resp_ready low for 20 cycles → resp_valid and data held stable; the other requester's req stays pending and is granted 2 cycles after the handshake.
6. Reset asserted in ARGMAX → all outputs 0 asynchronously; after release, req=2'b10 grants requester 0 first if both request, otherwise requester 1. No stale response is issued.
